// File: rtl/pktctrl_mem_pkg.sv
// Shared definitions for the capture bank controller: FSM encoding, read
// latency and a constant-friendly ceil(log2) helper.
package pktctrl_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } cap_state_e;

    // Request cycle to rd_vld pulse, counting the SRAM's own cycle.
    localparam int READ_LAT = 3;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Readback pipe: tracks accepted reads through the SRAM latency and selects
// the answering bank's Q into a held rd_data register.
module mem_rd_pipe
    import pktctrl_mem_pkg::*;
#(
    parameter int NUM_BANKS = 24,
    parameter int DATA_W    = 36,
    parameter int BANK_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_fire,
    input  logic                          rd_ok,
    input  logic [BANK_W-1:0]             rd_bank,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_q,
    output logic                          rd_vld,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int STAGES = READ_LAT - 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] ok_q, ok_d;
    logic [BANK_W-1:0] bank_q [STAGES];
    logic [BANK_W-1:0] bank_d [STAGES];
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] sel_s;

    // Delay line shift and AND-OR selection of the answering bank.
    always_comb begin
        vld_d     = {vld_q[STAGES-2:0], rd_fire};
        ok_d      = {ok_q[STAGES-2:0], rd_ok};
        bank_d[0] = rd_bank;
        for (int i = 1; i < STAGES; i++) begin
            bank_d[i] = bank_q[i-1];
        end
        sel_s = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            sel_s = sel_s | (mem_q[i*DATA_W +: DATA_W] &
                             {DATA_W{bank_q[STAGES-1] == BANK_W'(i)}});
        end
        rd_vld_d = vld_q[STAGES-1];
        if (vld_q[STAGES-1]) begin
            rd_data_d = ok_q[STAGES-1] ? sel_s : '0;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Pipe registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            ok_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            ok_q      <= ok_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < STAGES; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_bank_ctrl.sv
// Capture bank controller: stripes an ADC write stream round-robin over
// single-port SRAM banks and serves fixed-latency random readback.
module capture_bank_ctrl
    import pktctrl_mem_pkg::*;
#(
    parameter int  NUM_BANKS = 24,
    parameter int  ADDR_W    = 15,
    parameter int  DATA_W    = 36,
    parameter int  DEPTH     = 32768,
    localparam int BANK_W    = clog2(NUM_BANKS),
    localparam int CNT_W     = clog2(NUM_BANKS * DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cap_start,
    input  logic                          cap_stop,
    input  logic                          cap_mode,
    input  logic                          wr_vld,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_rdy,
    input  logic                          rd_req,
    input  logic [BANK_W-1:0]             rd_bank,
    input  logic [ADDR_W-1:0]             rd_row,
    output logic                          rd_rdy,
    output logic                          rd_vld,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          cap_full,
    output logic                          cap_wrap,
    output logic [CNT_W-1:0]              wr_cnt,
    output logic [NUM_BANKS-1:0]          mem_ceb,
    output logic [NUM_BANKS-1:0]          mem_web,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_a,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_d,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_q
);

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_BANKS * DEPTH);

    cap_state_e                  state_q, state_d;
    logic [BANK_W-1:0]           bank_ptr_q, bank_ptr_d;
    logic [ADDR_W-1:0]           row_ptr_q, row_ptr_d;
    logic                        mode_q, mode_d;
    logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
    logic                        cap_wrap_q, cap_wrap_d;
    logic [NUM_BANKS-1:0]        mem_ceb_q, mem_ceb_d;
    logic [NUM_BANKS-1:0]        mem_web_q, mem_web_d;
    logic [NUM_BANKS*ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [NUM_BANKS*DATA_W-1:0] mem_d_q, mem_d_d;

    logic wr_rdy_s, wr_fire_s, rd_rdy_s, rd_fire_s, rd_ok_s, ptr_end_s;

    assign wr_rdy_s  = (state_q == ST_CAPTURE) && !cap_start;
    assign wr_fire_s = wr_vld && wr_rdy_s;
    // The write owns its bank this cycle; a read aimed there must wait.
    assign rd_rdy_s  = !(wr_fire_s && (rd_bank == bank_ptr_q));
    assign rd_fire_s = rd_req && rd_rdy_s;
    assign rd_ok_s   = (int'(rd_bank) < NUM_BANKS) && (int'(rd_row) < DEPTH);
    assign ptr_end_s = (bank_ptr_q == LAST_BANK) && (row_ptr_q == LAST_ROW);

    // Capture FSM next state, pointer advance and status.
    always_comb begin
        state_d    = state_q;
        bank_ptr_d = bank_ptr_q;
        row_ptr_d  = row_ptr_q;
        mode_d     = mode_q;
        wr_cnt_d   = wr_cnt_q;
        cap_wrap_d = cap_wrap_q;
        if (cap_start) begin
            state_d    = ST_CAPTURE;
            bank_ptr_d = '0;
            row_ptr_d  = '0;
            wr_cnt_d   = '0;
            cap_wrap_d = 1'b0;
            mode_d     = cap_mode;
        end else begin
            if (wr_fire_s) begin
                wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                if (bank_ptr_q != LAST_BANK) begin
                    bank_ptr_d = bank_ptr_q + BANK_W'(1);
                end else if (row_ptr_q != LAST_ROW) begin
                    bank_ptr_d = '0;
                    row_ptr_d  = row_ptr_q + ADDR_W'(1);
                end else if (mode_q) begin
                    bank_ptr_d = '0;
                    row_ptr_d  = '0;
                    cap_wrap_d = 1'b1;
                end else begin
                    bank_ptr_d = bank_ptr_q;
                end
            end else begin
                wr_cnt_d = wr_cnt_q;
            end
            if (cap_stop) begin
                state_d = ST_IDLE;
            end else if (wr_fire_s && ptr_end_s && !mode_q) begin
                state_d = ST_FULL;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Per-bank port strobes; write and read never target the same bank.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_d_d = mem_d_q;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (wr_fire_s && (bank_ptr_q == BANK_W'(i))) begin
                mem_ceb_d[i]                  = 1'b0;
                mem_web_d[i]                  = 1'b0;
                mem_a_d[i*ADDR_W +: ADDR_W]   = row_ptr_q;
                mem_d_d[i*DATA_W +: DATA_W]   = wr_data;
            end else if (rd_fire_s && rd_ok_s && (rd_bank == BANK_W'(i))) begin
                mem_ceb_d[i]                  = 1'b0;
                mem_web_d[i]                  = 1'b1;
                mem_a_d[i*ADDR_W +: ADDR_W]   = rd_row;
            end else begin
                mem_ceb_d[i]                  = 1'b1;
                mem_web_d[i]                  = 1'b1;
            end
        end
    end

    // Control and SRAM port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bank_ptr_q <= '0;
            row_ptr_q  <= '0;
            mode_q     <= 1'b0;
            wr_cnt_q   <= '0;
            cap_wrap_q <= 1'b0;
            mem_ceb_q  <= '1;
            mem_web_q  <= '1;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            bank_ptr_q <= bank_ptr_d;
            row_ptr_q  <= row_ptr_d;
            mode_q     <= mode_d;
            wr_cnt_q   <= wr_cnt_d;
            cap_wrap_q <= cap_wrap_d;
            mem_ceb_q  <= mem_ceb_d;
            mem_web_q  <= mem_web_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
        end
    end

    mem_rd_pipe #(
        .NUM_BANKS (NUM_BANKS),
        .DATA_W    (DATA_W),
        .BANK_W    (BANK_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_fire (rd_fire_s),
        .rd_ok   (rd_ok_s),
        .rd_bank (rd_bank),
        .mem_q   (mem_q),
        .rd_vld  (rd_vld),
        .rd_data (rd_data)
    );

    assign wr_rdy   = wr_rdy_s;
    assign rd_rdy   = rd_rdy_s;
    assign cap_full = (state_q == ST_FULL);
    assign cap_wrap = cap_wrap_q;
    assign wr_cnt   = wr_cnt_q;
    assign mem_ceb  = mem_ceb_q;
    assign mem_web  = mem_web_q;
    assign mem_a    = mem_a_q;
    assign mem_d    = mem_d_q;

endmodule

// File: tb/tb_capture_bank_ctrl.sv
// Directed bench: a 4-bank/8-row instance backed by an SRAM model and a
// default 24-bank instance for reset and out-of-range readback.
module tb_capture_bank_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small instance: 4 banks, 8 rows, 4-bit address, 16-bit data.
    logic        s_cap_start, s_cap_stop, s_cap_mode, s_wr_vld, s_wr_rdy;
    logic [15:0] s_wr_data, s_rd_data;
    logic        s_rd_req, s_rd_rdy, s_rd_vld, s_cap_full, s_cap_wrap;
    logic [1:0]  s_rd_bank;
    logic [3:0]  s_rd_row;
    logic [5:0]  s_wr_cnt;
    logic [3:0]  s_mem_ceb, s_mem_web;
    logic [15:0] s_mem_a;
    logic [63:0] s_mem_d, s_mem_q;
    logic [15:0] sram_s [4][16];
    logic [15:0] q_s [4];

    // Large instance with default parameters.
    logic         l_cap_start, l_cap_stop, l_cap_mode, l_wr_vld, l_wr_rdy;
    logic [35:0]  l_wr_data, l_rd_data;
    logic         l_rd_req, l_rd_rdy, l_rd_vld, l_cap_full, l_cap_wrap;
    logic [4:0]   l_rd_bank;
    logic [14:0]  l_rd_row;
    logic [19:0]  l_wr_cnt;
    logic [23:0]  l_mem_ceb, l_mem_web;
    logic [359:0] l_mem_a;
    logic [863:0] l_mem_d, l_mem_q;

    assign l_mem_q = {864{1'b1}};
    assign s_mem_q = {q_s[3], q_s[2], q_s[1], q_s[0]};

    capture_bank_ctrl #(.NUM_BANKS(4), .ADDR_W(4), .DATA_W(16), .DEPTH(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .cap_start(s_cap_start), .cap_stop(s_cap_stop),
        .cap_mode(s_cap_mode), .wr_vld(s_wr_vld), .wr_data(s_wr_data), .wr_rdy(s_wr_rdy),
        .rd_req(s_rd_req), .rd_bank(s_rd_bank), .rd_row(s_rd_row), .rd_rdy(s_rd_rdy),
        .rd_vld(s_rd_vld), .rd_data(s_rd_data), .cap_full(s_cap_full), .cap_wrap(s_cap_wrap),
        .wr_cnt(s_wr_cnt), .mem_ceb(s_mem_ceb), .mem_web(s_mem_web), .mem_a(s_mem_a),
        .mem_d(s_mem_d), .mem_q(s_mem_q)
    );

    capture_bank_ctrl u_dut_l (
        .clk(clk), .rst_n(rst_n), .cap_start(l_cap_start), .cap_stop(l_cap_stop),
        .cap_mode(l_cap_mode), .wr_vld(l_wr_vld), .wr_data(l_wr_data), .wr_rdy(l_wr_rdy),
        .rd_req(l_rd_req), .rd_bank(l_rd_bank), .rd_row(l_rd_row), .rd_rdy(l_rd_rdy),
        .rd_vld(l_rd_vld), .rd_data(l_rd_data), .cap_full(l_cap_full), .cap_wrap(l_cap_wrap),
        .wr_cnt(l_wr_cnt), .mem_ceb(l_mem_ceb), .mem_web(l_mem_web), .mem_a(l_mem_a),
        .mem_d(l_mem_d), .mem_q(l_mem_q)
    );

    // Single-port SRAM model, one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!s_mem_ceb[b]) begin
                if (!s_mem_web[b]) sram_s[b][s_mem_a[b*4 +: 4]] <= s_mem_d[b*16 +: 16];
                else q_s[b] <= sram_s[b][s_mem_a[b*4 +: 4]];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  bb_bank [3] = '{2'd0, 2'd3, 2'd1};
    logic [3:0]  bb_row  [3] = '{4'd0, 4'd7, 4'd2};
    logic [15:0] bb_exp  [3] = '{16'd0, 16'd31, 16'd9};

    initial begin
        for (int b = 0; b < 4; b++) begin
            q_s[b] = 16'h0;
            for (int r = 0; r < 16; r++) sram_s[b][r] = 16'h0;
        end
        {s_cap_start, s_cap_stop, s_cap_mode, s_wr_vld, s_rd_req} = 5'b0;
        {l_cap_start, l_cap_stop, l_cap_mode, l_wr_vld, l_rd_req} = 5'b0;
        s_wr_data = 16'h0; s_rd_bank = 2'd0; s_rd_row = 4'd0;
        l_wr_data = 36'h0; l_rd_bank = 5'd0; l_rd_row = 15'd0;

        // Reset values of the 24-bank instance.
        tick; tick;
        check_eq("rst_ceb", 64'(l_mem_ceb), 64'hFFFFFF);
        check_eq("rst_web", 64'(l_mem_web), 64'hFFFFFF);
        check_eq("rst_rd_vld", 64'(l_rd_vld), 64'd0);
        check_eq("rst_wr_rdy", 64'(l_wr_rdy), 64'd0);
        check_eq("rst_wr_cnt", 64'(l_wr_cnt), 64'd0);
        check_eq("rst_a_d_zero", 64'({|l_mem_a, |l_mem_d}), 64'd0);
        check_eq("rst_status", 64'({l_cap_full, l_cap_wrap, l_rd_data}), 64'd0);
        rst_n = 1'b1;
        tick;

        // Stop-on-full: cap_start with a concurrent word must not write it.
        s_cap_mode = 1'b0; s_cap_start = 1'b1; s_wr_vld = 1'b1; s_wr_data = 16'hBEEF;
        #1 check_eq("start_wr_rdy", 64'(s_wr_rdy), 64'd0);
        tick;
        s_cap_start = 1'b0; s_wr_vld = 1'b0;
        check_eq("start_no_write", 64'(s_mem_ceb), 64'hF);
        for (int i = 0; i < 32; i++) begin
            s_wr_vld = 1'b1; s_wr_data = 16'(i);
            #1 check_eq("m0_wr_rdy", 64'(s_wr_rdy), 64'd1);
            tick;
        end
        s_wr_data = 16'h0999;
        check_eq("m0_full", 64'(s_cap_full), 64'd1);
        check_eq("m0_wr_rdy_full", 64'(s_wr_rdy), 64'd0);
        check_eq("m0_wr_cnt", 64'(s_wr_cnt), 64'd32);
        tick;
        s_wr_vld = 1'b0;
        check_eq("m0_33rd_blocked", 64'(s_mem_ceb), 64'hF);
        tick;
        check_eq("m0_b0r0", 64'(sram_s[0][0]), 64'd0);
        check_eq("m0_b1r3", 64'(sram_s[1][3]), 64'd13);
        check_eq("m0_b2r5", 64'(sram_s[2][5]), 64'd22);
        check_eq("m0_b3r7", 64'(sram_s[3][7]), 64'd31);

        // Single read of bank 2 row 5 with full latency trace.
        s_rd_req = 1'b1; s_rd_bank = 2'd2; s_rd_row = 4'd5;
        #1 check_eq("rd_rdy_idle", 64'(s_rd_rdy), 64'd1);
        tick;
        s_rd_req = 1'b0;
        check_eq("rd_ceb", 64'(s_mem_ceb), 64'b1011);
        check_eq("rd_web", 64'(s_mem_web), 64'hF);
        check_eq("rd_a", 64'(s_mem_a[8 +: 4]), 64'd5);
        tick;
        check_eq("rd_vld_early", 64'(s_rd_vld), 64'd0);
        tick;
        check_eq("rd_vld", 64'(s_rd_vld), 64'd1);
        check_eq("rd_data", 64'(s_rd_data), 64'd22);
        tick;
        check_eq("rd_vld_pulse", 64'(s_rd_vld), 64'd0);
        check_eq("rd_data_hold", 64'(s_rd_data), 64'd22);

        // Back-to-back reads return in order, one per cycle.
        for (int c = 0; c < 5; c++) begin
            s_rd_req = (c < 3);
            if (c < 3) begin
                s_rd_bank = bb_bank[c]; s_rd_row = bb_row[c];
            end
            tick;
            if (c >= 2) begin
                check_eq("bb_vld", 64'(s_rd_vld), 64'd1);
                check_eq("bb_data", 64'(s_rd_data), 64'(bb_exp[c-2]));
            end
        end
        s_rd_req = 1'b0;

        // Circular mode: 40 writes wrap once.
        s_cap_mode = 1'b1; s_cap_start = 1'b1;
        tick;
        s_cap_start = 1'b0;
        check_eq("m1_cnt_clear", 64'(s_wr_cnt), 64'd0);
        check_eq("m1_full_clear", 64'(s_cap_full), 64'd0);
        for (int i = 0; i < 40; i++) begin
            s_wr_vld = 1'b1; s_wr_data = 16'(i);
            tick;
        end
        s_wr_vld = 1'b0;
        tick;
        check_eq("m1_wrap", 64'(s_cap_wrap), 64'd1);
        check_eq("m1_wr_cnt_sat", 64'(s_wr_cnt), 64'd32);
        check_eq("m1_not_full", 64'(s_cap_full), 64'd0);
        check_eq("m1_b0r0", 64'(sram_s[0][0]), 64'd32);
        check_eq("m1_b3r1", 64'(sram_s[3][1]), 64'd39);
        check_eq("m1_b0r2", 64'(sram_s[0][2]), 64'd8);

        // Collision: write to bank 1 stalls a read of bank 1 for a cycle.
        s_wr_vld = 1'b1; s_wr_data = 16'h0100;
        tick;
        s_wr_data = 16'h0101; s_rd_req = 1'b1; s_rd_bank = 2'd1; s_rd_row = 4'd0;
        #1 check_eq("col_rd_rdy", 64'(s_rd_rdy), 64'd0);
        tick;
        s_wr_vld = 1'b0;
        #1 check_eq("col_rd_rdy_next", 64'(s_rd_rdy), 64'd1);
        check_eq("col_wr_strobe", 64'({s_mem_ceb, s_mem_web}), 64'hDD);
        tick;
        s_rd_req = 1'b0;
        check_eq("col_rd_strobe", 64'({s_mem_ceb, s_mem_web}), 64'hDF);
        check_eq("col_rd_a", 64'(s_mem_a[4 +: 4]), 64'd0);
        tick; tick;
        check_eq("col_rd_vld", 64'(s_rd_vld), 64'd1);
        check_eq("col_rd_data", 64'(s_rd_data), 64'd33);

        // Parallel: write bank 2 while reading bank 3.
        s_wr_vld = 1'b1; s_wr_data = 16'h0202; s_rd_req = 1'b1; s_rd_bank = 2'd3; s_rd_row = 4'd1;
        #1 check_eq("par_rd_rdy", 64'(s_rd_rdy), 64'd1);
        tick;
        s_wr_vld = 1'b0; s_rd_req = 1'b0;
        check_eq("par_ceb", 64'(s_mem_ceb), 64'b0011);
        check_eq("par_web", 64'(s_mem_web), 64'b1011);
        check_eq("par_a", 64'({s_mem_a[12 +: 4], s_mem_a[8 +: 4]}), 64'h12);
        check_eq("par_d", 64'(s_mem_d[32 +: 16]), 64'h0202);
        tick; tick;
        check_eq("par_rd_vld", 64'(s_rd_vld), 64'd1);
        check_eq("par_rd_data", 64'(s_rd_data), 64'd39);

        // Out-of-range row on the small instance.
        s_rd_req = 1'b1; s_rd_bank = 2'd1; s_rd_row = 4'd9;
        tick;
        s_rd_req = 1'b0;
        check_eq("oor_row_ceb", 64'(s_mem_ceb), 64'hF);
        tick; tick;
        check_eq("oor_row_vld", 64'(s_rd_vld), 64'd1);
        check_eq("oor_row_data", 64'(s_rd_data), 64'd0);

        // cap_stop leaves capture with counters retained.
        s_cap_stop = 1'b1;
        tick;
        s_cap_stop = 1'b0;
        check_eq("stop_wr_rdy", 64'(s_wr_rdy), 64'd0);
        check_eq("stop_cnt_kept", 64'({s_cap_wrap, s_wr_cnt}), 64'h60);

        // Large instance: in-range read, then rd_bank = 30.
        l_rd_req = 1'b1; l_rd_bank = 5'd5; l_rd_row = 15'd3;
        tick;
        l_rd_req = 1'b0;
        check_eq("l_rd_ceb", 64'(l_mem_ceb), 64'hFFFFDF);
        tick; tick;
        check_eq("l_rd_data", 64'(l_rd_data), 64'hF_FFFF_FFFF);
        l_rd_req = 1'b1; l_rd_bank = 5'd30; l_rd_row = 15'd0;
        #1 check_eq("l_oor_rdy", 64'(l_rd_rdy), 64'd1);
        tick;
        l_rd_req = 1'b0;
        check_eq("l_oor_ceb", 64'(l_mem_ceb), 64'hFFFFFF);
        tick;
        check_eq("l_oor_vld_early", 64'(l_rd_vld), 64'd0);
        tick;
        check_eq("l_oor_vld", 64'(l_rd_vld), 64'd1);
        check_eq("l_oor_data", 64'(l_rd_data), 64'd0);

        // Asynchronous reset while a read is in flight.
        s_rd_req = 1'b1; s_rd_bank = 2'd2; s_rd_row = 4'd5;
        tick;
        s_rd_req = 1'b0;
        tick;
        #1 rst_n = 1'b0;
        #1 check_eq("arst_ceb", 64'(s_mem_ceb), 64'hF);
        tick;
        check_eq("arst_rd_vld", 64'(s_rd_vld), 64'd0);
        check_eq("arst_status", 64'({s_cap_wrap, s_wr_cnt}), 64'd0);
        rst_n = 1'b1;
        tick;
        check_eq("arst_rd_vld_after", 64'(s_rd_vld), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/capture_bank_ctrl.md
Name: capture_bank_ctrl

Overview:
- Parametrised controller for an array of single-port SRAM banks (active-low CEB/WEB macros, 1-cycle read latency) in the ADC capture path.
- Accepts a capture write stream and stripes words round-robin across NUM_BANKS banks.
- Supports stop-on-full and circular capture modes.
- Serves random-access readback with a fixed-latency valid pipeline; a write has priority over a read to the same bank.

Parameters:
- NUM_BANKS, 24, number of SRAM banks (any value >= 2, not necessarily a power of 2).
- ADDR_W, 15, SRAM address width.
- DATA_W, 36, SRAM word width.
- DEPTH, 32768, rows used per bank (<= 2**ADDR_W).
- Derived localparams: BANK_W = clog2(NUM_BANKS); CNT_W = clog2(NUM_BANKS*DEPTH+1).

Ports:
- clk  in  1  single clock for the block and all banks.
- rst_n  in  1  asynchronous active-low reset.
- cap_start  in  1  pulse: clear pointers and status, enter CAPTURE, sample cap_mode.
- cap_stop  in  1  pulse: leave capture, pointers retained.
- cap_mode  in  1  0 = stop-on-full, 1 = circular.
- wr_vld  in  1  write word valid.
- wr_data  in  DATA_W  write word.
- wr_rdy  out  1  write accepted when wr_vld && wr_rdy.
- rd_req  in  1  read request.
- rd_bank  in  BANK_W  read bank index.
- rd_row  in  ADDR_W  read row.
- rd_rdy  out  1  read accepted when rd_req && rd_rdy.
- rd_vld  out  1  read data valid.
- rd_data  out  DATA_W  read data.
- cap_full  out  1  stop-on-full capture complete.
- cap_wrap  out  1  sticky: circular capture has wrapped at least once.
- wr_cnt  out  CNT_W  words written since cap_start, saturates at NUM_BANKS*DEPTH.
- mem_ceb  out  NUM_BANKS  per-bank chip enable, active low.
- mem_web  out  NUM_BANKS  per-bank write enable, active low.
- mem_a  out  NUM_BANKS*ADDR_W  per-bank address, bank i at [i*ADDR_W +: ADDR_W].
- mem_d  out  NUM_BANKS*DATA_W  per-bank write data.
- mem_q  in  NUM_BANKS*DATA_W  per-bank read data.

Behaviour:
- Reset values: mem_ceb/mem_web all 1; mem_a, mem_d, rd_data, wr_cnt 0; rd_vld, cap_full, cap_wrap, wr_rdy 0.
- Reset state is IDLE, bank_ptr = row_ptr = 0. Reset mid-operation flushes the read pipe; no rd_vld is issued for in-flight reads.
- FSM states:
  - IDLE: wr_rdy = 0.
  - CAPTURE: wr_rdy = !cap_start.
  - FULL: wr_rdy = 0, cap_full = 1.
- FSM transitions:
  - cap_start from any state -> CAPTURE; clears pointers, wr_cnt, cap_full, cap_wrap; latches cap_mode.
  - cap_stop -> IDLE. cap_start wins over cap_stop when both are asserted in the same cycle.
- Write timing: a word accepted in cycle N drives bank bank_ptr in cycle N+1 with ceb = 0, web = 0, a = row_ptr, d = wr_data. All mem_* outputs are registered. Disabled banks hold ceb = 1, web = 1, and their previous a/d.
- Pointer advance on each accepted write:
  - bank_ptr increments. At NUM_BANKS-1 it wraps to 0 and row_ptr increments.
  - At (NUM_BANKS-1, DEPTH-1), mode 0: go to FULL, pointers stay.
  - At (NUM_BANKS-1, DEPTH-1), mode 1: pointers go to 0, cap_wrap is set, state stays CAPTURE.
  - wr_cnt saturates at NUM_BANKS*DEPTH.
- Read port and collision rule:
  - rd_rdy = !(wr_vld && wr_rdy && rd_bank == bank_ptr), so a write to the same bank in the same cycle stalls the read.
  - Reads are allowed in every state.
  - Reads to different banks in the same cycle as a write proceed in parallel.
- Read timing: a read accepted in cycle N drives the bank port (ceb = 0, web = 1, a = rd_row) in N+1. The SRAM presents Q in N+2, captured into rd_data. rd_vld is a 1-cycle pulse in N+3. Fixed READ_LAT = 3; back-to-back reads give one result per cycle in order.
- Out-of-range reads (rd_bank >= NUM_BANKS or rd_row >= DEPTH) are accepted, enable no bank, and return rd_data = 0 with rd_vld at N+3.
- rd_data holds its value between rd_vld pulses.

Decomposition:
- Shared package pktctrl_mem_pkg:
  - FSM state encodings (IDLE / CAPTURE / FULL).
  - READ_LAT = 3.
  - clog2 function.
- Sub-module mem_rd_pipe:
  - 2-stage valid and bank-index delay line.
  - NUM_BANKS:1 mem_q mux with out-of-range zeroing.
  - rd_data/rd_vld registers.

Test Plan:
- Reset with NUM_BANKS=24 -> all mem_ceb/mem_web = 24'hFFFFFF; rd_vld, wr_rdy, wr_cnt = 0; asynchronous assertion mid-read kills the pending rd_vld.
- NUM_BANKS=4, DEPTH=8, mode 0: cap_start then 32 writes of data = index -> bank k row r holds 4r+k; cap_full = 1 after the 32nd write; wr_rdy = 0; a 33rd wr_vld is not written.
- Same configuration, mode 1, 40 writes -> cap_wrap = 1; bank 0 row 0 holds 32, bank 3 row 1 holds 39, bank 0 row 2 holds 8; wr_cnt = 32.
- Read bank 2 row 5 accepted in cycle N -> mem_ceb[2] = 0, mem_web[2] = 1, a = 5 in N+1; rd_vld pulses in N+3 with the stored word.
- Write to bank 1 concurrent with rd_req on bank 1 -> rd_rdy = 0 that cycle, read accepted next cycle. Concurrent rd_req on bank 2 -> accepted, both banks strobed in the same cycle.
- rd_bank = 30 with NUM_BANKS=24 -> no mem_ceb low, rd_data = 0, rd_vld pulses 3 cycles later; cap_start together with wr_vld -> wr_rdy = 0 and the word is not written.
